// File: rtl/nes_pad_reader_pkg.sv
// Shared game-pad types: poll FSM states, button bit indices and the decoded button record.
`timescale 1ns/1ps
package nes_pad_reader_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        CLK_HI = 3'd2,
        CLK_LO = 3'd3,
        DONE   = 3'd4
    } pad_state_t;

    localparam int unsigned PAD_BITS   = 8;
    localparam int unsigned PAD_A      = 0;
    localparam int unsigned PAD_B      = 1;
    localparam int unsigned PAD_SELECT = 2;
    localparam int unsigned PAD_START  = 3;
    localparam int unsigned PAD_UP     = 4;
    localparam int unsigned PAD_DOWN   = 5;
    localparam int unsigned PAD_LEFT   = 6;
    localparam int unsigned PAD_RIGHT  = 7;

    // First member is the MSB, so 'a' lands on bit 0 to match the serial order.
    typedef struct packed {
        logic right;
        logic left;
        logic down;
        logic up;
        logic start;
        logic select;
        logic b;
        logic a;
    } pad_buttons_t;

    // Controller data is active-low; a set bit in the record means "held".
    function automatic pad_buttons_t pad_decode(input logic [PAD_BITS-1:0] raw);
        return pad_buttons_t'(~raw);
    endfunction

endpackage

// File: rtl/nes_pad_reader_phase_timer.sv
// nes_phase_timer: loadable down-counter that flags the last cycle of a timed phase.
`timescale 1ns/1ps
module nes_phase_timer #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire_c
);

    logic [W-1:0] count_q;
    logic         running_q;

    // A load restarts the phase; an unloaded timer stays quiet after expiring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else if (load) begin
            count_q   <= load_val;
            running_q <= 1'b1;
        end else if (running_q) begin
            if (count_q == '0) begin
                running_q <= 1'b0;
            end else begin
                count_q <= count_q - W'(1);
            end
        end
    end

    assign expire_c = running_q && (count_q == '0);

endmodule

// File: rtl/nes_pad_reader.sv
// NES controller poller: latch/clock generation, data sync, active-low decode once per frame.
// Optional NES_DEBOUNCE_EN: a button only changes after two consecutive agreeing polls.
`timescale 1ns/1ps
module nes_pad_reader #(
    parameter int unsigned HALF_PERIOD = 150,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic frame_tick,
    input  logic nes_data,
    output logic nes_latch,
    output logic nes_clk,
    output logic btn_A,
    output logic btn_B,
    output logic btn_select,
    output logic btn_start,
    output logic btn_up,
    output logic btn_down,
    output logic btn_left,
    output logic btn_right,
    output logic buttons_valid,
    output logic poll_busy
);

    import nes_pad_reader_pkg::*;

    localparam int unsigned CNT_W = $clog2(2 * HALF_PERIOD);
    localparam logic [CNT_W-1:0] LOAD_LATCH = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] LOAD_HALF  = CNT_W'(HALF_PERIOD - 1);

    pad_state_t          state, state_next;
    logic [2:0]          bit_idx, bit_idx_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                data_s;
    logic [PAD_BITS-1:0] raw_q;
    pad_buttons_t        btn_q;
    pad_buttons_t        btn_next_c;
    logic                timer_load_c;
    logic [CNT_W-1:0]    timer_val_c;
    logic                expire_c;
    logic                sample_c;

    nes_phase_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load_c),
        .load_val (timer_val_c),
        .expire_c (expire_c)
    );

    // Pad data is asynchronous; idle high reads as "nothing pressed".
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], nes_data};
        end
    end

    assign data_s = sync_q[SYNC_STAGES-1];

    // Next state; every phase entry reloads the timer so phases are exact.
    always_comb begin
        state_next   = state;
        bit_idx_next = bit_idx;
        timer_load_c = 1'b0;
        timer_val_c  = LOAD_HALF;
        sample_c     = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    state_next   = LATCH;
                    timer_load_c = 1'b1;
                    timer_val_c  = LOAD_LATCH;
                end
            end
            LATCH: begin
                if (expire_c) begin
                    sample_c     = 1'b1;
                    bit_idx_next = 3'(PAD_B);
                    state_next   = CLK_HI;
                    timer_load_c = 1'b1;
                end
            end
            CLK_HI: begin
                if (expire_c) begin
                    state_next   = CLK_LO;
                    timer_load_c = 1'b1;
                end
            end
            CLK_LO: begin
                if (expire_c) begin
                    sample_c = 1'b1;
                    if (bit_idx == 3'(PAD_RIGHT)) begin
                        state_next = DONE;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        state_next   = CLK_HI;
                        timer_load_c = 1'b1;
                    end
                end
            end
            DONE: begin
                bit_idx_next = 3'd0;
                state_next   = IDLE;
            end
            default: begin
                bit_idx_next = 3'd0;
                state_next   = IDLE;
            end
        endcase
    end

`ifdef NES_DEBOUNCE_EN
    logic [PAD_BITS-1:0] prev_q;
    logic [PAD_BITS-1:0] btn_bits;

    assign btn_bits = btn_q;

    // A bit only follows the pad when two consecutive raw samples agree.
    always_comb begin
        btn_next_c = btn_q;
        for (int i = 0; i < int'(PAD_BITS); i++) begin
            if (raw_q[i] == prev_q[i]) begin
                btn_next_c[i] = ~raw_q[i];
            end else begin
                btn_next_c[i] = btn_bits[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '1;
        end else if (state == DONE) begin
            prev_q <= raw_q;
        end
    end
`else
    assign btn_next_c = pad_decode(raw_q);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_idx       <= 3'd0;
            raw_q         <= '1;
            btn_q         <= '0;
            buttons_valid <= 1'b0;
            nes_latch     <= 1'b0;
            nes_clk       <= 1'b0;
            poll_busy     <= 1'b0;
        end else begin
            state         <= state_next;
            bit_idx       <= bit_idx_next;
            nes_latch     <= (state_next == LATCH);
            nes_clk       <= (state_next == CLK_HI);
            poll_busy     <= (state_next != IDLE);
            buttons_valid <= (state == DONE);
            if (sample_c) begin
                raw_q[bit_idx] <= data_s;
            end
            if (state == DONE) begin
                btn_q <= btn_next_c;
            end
        end
    end

    assign btn_A      = btn_q.a;
    assign btn_B      = btn_q.b;
    assign btn_select = btn_q.select;
    assign btn_start  = btn_q.start;
    assign btn_up     = btn_q.up;
    assign btn_down   = btn_q.down;
    assign btn_left   = btn_q.left;
    assign btn_right  = btn_q.right;

endmodule
